// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with tear-free display
// updates, leading-zero blanking and anti-ghost slot blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_TC =
    PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BL =
    PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST =
    IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF =
    (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [VW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;
  logic                  dis_q;

  logic                  tc;
  logic                  wrap;
  logic                  forced;
  logic                  xfer;
  logic                  active;
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;
  logic [3:0]            nib;
  logic                  dpb;
  logic                  lzb;
  logic [6:0]            seg_on;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] dig_d;

  // Active-low glyph codes, bit0 = a ... bit6 = g.
  function automatic logic [6:0] glyph(
    input logic [3:0] n
  );
    logic [6:0] c;
    unique case (n)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h18;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      4'hF: c = 7'h0E;
    endcase
    return c;
  endfunction

  assign tc     = enable && (presc == P_TC);
  assign wrap   = tc && (idx == I_LAST);
  // First enabled cycle after an idle period restarts
  // the frame, so pending data is committed there too.
  assign forced = enable && dis_q;
  assign xfer   = wrap || forced;
  assign active = enable && (presc >= P_BL);

  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run = run
          && (disp_val[4*k +: 4] == 4'h0)
          && !disp_dp[k];
      lz[k] = run && (k != 0) && (BLANK_LZ != 0);
    end
  end

  always_comb begin
    nib    = 4'h0;
    dpb    = 1'b0;
    lzb    = 1'b0;
    onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        nib       = disp_val[4*k +: 4];
        dpb       = disp_dp[k];
        lzb       = lz[k];
        onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_on = 7'h00;
    dp_d   = DP_OFF;
    dig_d  = DIG_OFF;
    if (active) begin
      dig_d = onehot ^ DIG_OFF;
      dp_d  = dpb ^ DP_OFF;
      if (!lzb)
        seg_on = ~glyph(nib);
    end
    seg_d = seg_on ^ SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      dis_q      <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      dis_q <= !enable;

      if (!enable) begin
        presc <= '0;
        idx   <= '0;
      end else if (tc) begin
        presc <= '0;
        idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (xfer) begin
        pend_valid <= 1'b0;
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
        end else if (pend_valid) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end

      seg        <= seg_d;
      dp         <= dp_d;
      dig_sel    <= dig_d;
      frame_done <= wrap;
    end
  end

endmodule
